periodic_framer_gen: RTL

// Generalised periodic framer for the OFDM receive chain: sits after the Schmidl-Cox

---
 rtl/periodic_framer_gen_if.sv | 41 ++++
 rtl/periodic_framer_gen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/periodic_framer_gen_if.sv
// Stream and settings-bus bundle for periodic_framer_gen.
//   set_stb/set_addr/set_data : settings write port (register block)
//   i_tdata/i_ttrig/i_tvalid/i_tready : input sample stream, i_ttrig marks a detector hit
//   o_tdata/o_tlast/o_frame_idx/o_tvalid/o_tready : framed output stream
// master = the side that drives settings and input samples and consumes output;
// slave  = the framer itself.
interface periodic_framer_gen_if #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 8
);
    logic              set_stb;
    logic [7:0]        set_addr;
    logic [31:0]       set_data;

    logic [WIDTH-1:0]  i_tdata;
    logic              i_ttrig;
    logic              i_tvalid;
    logic              i_tready;

    logic [WIDTH-1:0]  o_tdata;
    logic              o_tlast;
    logic [IDX_W-1:0]  o_frame_idx;
    logic              o_tvalid;
    logic              o_tready;

    modport master (
        output set_stb, set_addr, set_data,
        output i_tdata, i_ttrig, i_tvalid,
        input  i_tready,
        input  o_tdata, o_tlast, o_frame_idx, o_tvalid,
        output o_tready
    );

    modport slave (
        input  set_stb, set_addr, set_data,
        input  i_tdata, i_ttrig, i_tvalid,
        output i_tready,
        output o_tdata, o_tlast, o_frame_idx, o_tvalid,
        input  o_tready
    );
endinterface

// File: rtl/periodic_framer_gen.sv
// Periodic framer: after a trigger sample, skip OFFSET beats, then repeatedly forward
// FRAME_LEN beats (tlast on the last) and drop GAP_LEN beats, for MAX_FRAMES frames
// (0 = run until reset or retrigger).
// Ports:
//   ce_clk      clock
//   ce_rst      asynchronous reset, active low
//   bus         settings + input/output streams (slave view)
//   busy        high whenever a burst is in progress
//   frames_done frames completed in the current/last burst (saturating)
//
// state | meaning
// IDLE  | waiting for a trigger beat, input beats dropped
// OFFS  | dropping the remaining offset beats after the trigger
// FRAME | forwarding frame samples
// GAP   | dropping cyclic-prefix beats between frames
module periodic_framer_gen #(
    parameter int WIDTH   = 32,
    parameter int CNT_W   = 16,
    parameter int IDX_W   = 8,
    parameter int SR_BASE = 130
) (
    input  logic                 ce_clk,
    input  logic                 ce_rst,
    periodic_framer_gen_if.slave bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     frames_done
);
    typedef enum logic [1:0] {IDLE, OFFS, FRAME, GAP} state_t;

    localparam logic [7:0] A_FRAME = 8'(SR_BASE);
    localparam logic [7:0] A_GAP   = 8'(SR_BASE + 1);
    localparam logic [7:0] A_OFFS  = 8'(SR_BASE + 2);
    localparam logic [7:0] A_MAX   = 8'(SR_BASE + 3);
    localparam logic [7:0] A_MODE  = 8'(SR_BASE + 4);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    logic [CNT_W-1:0] frame_len, gap_len, offset, max_frames;
    logic             retrig;
    logic [CNT_W-1:0] sh_len, sh_gap, sh_max;
    logic             sh_retrig;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d, done_d;
    logic [IDX_W-1:0] frame_idx, idx_d;

    logic             beat, start, fwd, tlast_d;
    logic [CNT_W-1:0] e_len, e_gap, e_max, e_cnt, e_done, done_inc;
    logic [IDX_W-1:0] e_idx;
    logic [CNT_W-1:0] wr_val;
    logic             unused_set_bits;

    assign wr_val          = bus.set_data[CNT_W-1:0];
    assign unused_set_bits = ^bus.set_data;

    always_ff @(posedge ce_clk or negedge ce_rst) begin
        if (!ce_rst) begin
            frame_len  <= CNT_W'(64);
            gap_len    <= CNT_W'(16);
            offset     <= '0;
            max_frames <= ONE;
            retrig     <= 1'b0;
        end else if (bus.set_stb) begin
            case (bus.set_addr)
                A_FRAME: frame_len  <= (wr_val == '0) ? ONE : wr_val;
                A_GAP:   gap_len    <= wr_val;
                A_OFFS:  offset     <= wr_val;
                A_MAX:   max_frames <= wr_val;
                A_MODE:  retrig     <= bus.set_data[0];
                default: ;
            endcase
        end
    end

    assign bus.i_tready = ~bus.o_tvalid | bus.o_tready;
    assign beat         = bus.i_tvalid & bus.i_tready;
    // A trigger restarts the burst from IDLE, or from anywhere when the running
    // burst was latched with retrigger enabled.
    assign start        = beat & bus.i_ttrig & ((state == IDLE) | sh_retrig);

    // On a starting beat the fresh register values apply to that very beat,
    // otherwise the shadows of the running burst.
    assign e_len    = start ? frame_len : sh_len;
    assign e_gap    = start ? gap_len : sh_gap;
    assign e_max    = start ? max_frames : sh_max;
    assign e_cnt    = start ? frame_len - ONE : cnt;
    assign e_done   = start ? '0 : frames_done;
    assign e_idx    = start ? '0 : frame_idx;
    assign done_inc = (e_done == '1) ? e_done : e_done + ONE;

    always_ff @(posedge ce_clk or negedge ce_rst) begin
        if (!ce_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            frames_done <= '0;
            frame_idx   <= '0;
            sh_len      <= CNT_W'(64);
            sh_gap      <= CNT_W'(16);
            sh_max      <= ONE;
            sh_retrig   <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            frames_done <= done_d;
            frame_idx   <= idx_d;
            if (start) begin
                sh_len    <= frame_len;
                sh_gap    <= gap_len;
                sh_max    <= max_frames;
                sh_retrig <= retrig;
            end
        end
    end

    // cnt holds the beats still to go in the current phase minus one.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        done_d  = frames_done;
        idx_d   = frame_idx;
        if (beat) begin
            if (start) begin
                done_d = '0;
                idx_d  = '0;
            end
            if (fwd) begin
                if (e_cnt == '0) begin
                    done_d = done_inc;
                    idx_d  = e_idx + IDX_W'(1);
                    if ((e_max != '0) && (done_inc == e_max)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (e_gap == '0) begin
                        state_d = FRAME;
                        cnt_d   = e_len - ONE;
                    end else begin
                        state_d = GAP;
                        cnt_d   = e_gap - ONE;
                    end
                end else begin
                    state_d = FRAME;
                    cnt_d   = e_cnt - ONE;
                end
            end else if (start) begin
                // trigger beat itself counts as the first offset beat
                if (offset == ONE) begin
                    state_d = FRAME;
                    cnt_d   = frame_len - ONE;
                end else begin
                    state_d = OFFS;
                    cnt_d   = offset - TWO;
                end
            end else if ((state == OFFS) || (state == GAP)) begin
                if (cnt == '0) begin
                    state_d = FRAME;
                    cnt_d   = sh_len - ONE;
                end else begin
                    cnt_d = cnt - ONE;
                end
            end
        end
    end

    always_comb begin
        fwd     = beat & (start ? (offset == '0) : (state == FRAME));
        tlast_d = (e_cnt == '0);
        busy    = (state != IDLE);
    end

    always_ff @(posedge ce_clk or negedge ce_rst) begin
        if (!ce_rst) begin
            bus.o_tvalid    <= 1'b0;
            bus.o_tdata     <= '0;
            bus.o_tlast     <= 1'b0;
            bus.o_frame_idx <= '0;
        end else if (bus.i_tready) begin
            bus.o_tvalid <= fwd;
            if (fwd) begin
                bus.o_tdata     <= bus.i_tdata;
                bus.o_tlast     <= tlast_d;
                bus.o_frame_idx <= e_idx;
            end
        end
    end
endmodule
